// File: rtl/rom_load_pkg.sv
// rom_load_pkg: download region map, region index and sequencer state shared by
// the ROM load sequencer and its address decoder.
package rom_load_pkg;

    localparam logic [15:0] PROG_BASE = 16'h0000;
    localparam logic [15:0] PROG_SIZE = 16'h4000;
    localparam logic [15:0] BG_SIZE   = 16'h1000;
    localparam logic [15:0] FG_SIZE   = 16'h1000;
    localparam logic [15:0] PROM_SIZE = 16'h0200;
    localparam logic [15:0] BG_BASE   = PROG_BASE + PROG_SIZE;
    localparam logic [15:0] FG_BASE   = BG_BASE + BG_SIZE;
    localparam logic [15:0] PROM_BASE = FG_BASE + FG_SIZE;
    localparam logic [15:0] ROM_END   = PROM_BASE + PROM_SIZE;

    typedef enum logic [1:0] {PROG, BG, FG, PROM} region_e;

    typedef enum logic [2:0] {EMPTY, LOAD, CHECK, STRETCH, RUN, FAULT} state_e;

    function automatic logic [15:0] region_base(input region_e r);
        return r == PROG ? PROG_BASE : r == BG ? BG_BASE : r == FG ? FG_BASE : PROM_BASE;
    endfunction

    function automatic logic [3:0] region_onehot(input region_e r);
        return 4'(1) << r;
    endfunction

endpackage

// File: rtl/rom_region_decode.sv
// rom_region_decode: maps a linear download byte address to a one-hot region
// strobe and the address relative to that region's base.
module rom_region_decode
    import rom_load_pkg::*;
(
    input  logic [15:0] addr,
    output logic [3:0]  we,
    output logic [13:0] rel_addr,
    output logic        in_range
);

    region_e     region;
    logic [15:0] base;

    always_comb begin
        region   = addr < BG_BASE ? PROG : addr < FG_BASE ? BG : addr < PROM_BASE ? FG : PROM;
        base     = region_base(region);
        in_range = addr < ROM_END;
        we       = in_range ? region_onehot(region) : 4'b0000;
        rel_addr = 14'(addr - base);
    end

endmodule

// File: rtl/rom_load_sequencer.sv
// rom_load_sequencer: turns the HPS download stream into per-region ROM writes and
// keeps the core in reset until a complete, in-range image has been loaded.
module rom_load_sequencer
    import rom_load_pkg::*;
#(
    parameter int unsigned TOTAL_BYTES = 25088,
    parameter int unsigned RST_CYCLES  = 64
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        dl_active,
    input  logic        dl_wr,
    input  logic [15:0] dl_addr,
    input  logic [7:0]  dl_data,
    input  logic        soft_reset,
    output logic [3:0]  rom_we,
    output logic [13:0] rom_addr,
    output logic [7:0]  rom_data,
    output logic        core_reset,
    output logic        load_ok,
    output logic        load_err
);

    localparam int unsigned    RCW      = $clog2(RST_CYCLES);
    localparam logic [RCW-1:0] RST_LAST = RCW'(RST_CYCLES - 1);
    localparam logic [15:0]    TOTAL    = 16'(TOTAL_BYTES);

    state_e         state, state_n;
    logic [15:0]    byte_cnt;
    logic           addr_err;
    logic [RCW-1:0] rst_cnt;
    logic [3:0]     dec_we;
    logic [13:0]    dec_addr;
    logic           dec_in_range;
    logic           accept, load_good, enter_load;

    rom_region_decode u_dec (
        .addr    (dl_addr),
        .we      (dec_we),
        .rel_addr(dec_addr),
        .in_range(dec_in_range)
    );

    assign accept     = state == LOAD && dl_wr;
    assign load_good  = byte_cnt == TOTAL && !addr_err;
    assign enter_load = state != LOAD && state_n == LOAD;

    // A new download always wins, even over an in-progress reset stretch.
    always_comb begin
        state_n = state;
        case (state)
            EMPTY, FAULT: state_n = dl_active ? LOAD : state;
            LOAD:         state_n = dl_active ? LOAD : CHECK;
            CHECK:        state_n = load_good ? STRETCH : FAULT;
            STRETCH:      state_n = dl_active ? LOAD : (!soft_reset && rst_cnt == RST_LAST) ? RUN : STRETCH;
            RUN:          state_n = dl_active ? LOAD : soft_reset ? STRETCH : RUN;
            default:      state_n = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= EMPTY;
            byte_cnt   <= '0;
            addr_err   <= 1'b0;
            rst_cnt    <= '0;
            rom_we     <= '0;
            rom_addr   <= '0;
            rom_data   <= '0;
            core_reset <= 1'b1;
            load_ok    <= 1'b0;
            load_err   <= 1'b0;
        end else begin
            state      <= state_n;
            core_reset <= state_n != RUN;
            rom_we     <= '0;
            if (accept) begin
                rom_we   <= dec_we;
                rom_addr <= dec_addr;
                rom_data <= dl_data;
                byte_cnt <= byte_cnt + {15'd0, byte_cnt != 16'hFFFF};
                addr_err <= addr_err | !dec_in_range;
            end
            if (enter_load) begin
                byte_cnt <= '0;
                addr_err <= 1'b0;
                load_ok  <= 1'b0;
                load_err <= 1'b0;
            end
            if (state == CHECK) begin
                load_ok  <= load_good;
                load_err <= !load_good;
            end
            // Held at zero while soft_reset stays high so the stretch restarts on release.
            rst_cnt <= (state == STRETCH && state_n == STRETCH && !soft_reset) ? rst_cnt + 1'b1 : '0;
        end
    end

endmodule

// File: tb/tb_rom_load_sequencer.sv
// tb_rom_load_sequencer: directed downloads with a write scoreboard checked by a
// negedge monitor, plus flag and reset-stretch timing checks.
`timescale 1ns/1ps
module tb_rom_load_sequencer;

    typedef struct {
        logic [3:0]  we;
        logic [13:0] addr;
        logic [7:0]  data;
        int          bnd;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        dl_active = 1'b0;
    logic        dl_wr = 1'b0;
    logic [15:0] dl_addr = '0;
    logic [7:0]  dl_data = '0;
    logic        soft_reset = 1'b0;
    logic [3:0]  rom_we;
    logic [13:0] rom_addr;
    logic [7:0]  rom_data;
    logic        core_reset, load_ok, load_err;

    int          checks = 0;
    int          failures = 0;
    int          strobes = 0;
    int          reg_cnt[4];
    logic        bnd_seen[4];
    logic [3:0]  bnd_we[4];
    logic [13:0] bnd_addr[4];
    exp_t        sb[$];
    exp_t        m;

    always #5 clk = ~clk;

    rom_load_sequencer dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .dl_active (dl_active),
        .dl_wr     (dl_wr),
        .dl_addr   (dl_addr),
        .dl_data   (dl_data),
        .soft_reset(soft_reset),
        .rom_we    (rom_we),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .core_reset(core_reset),
        .load_ok   (load_ok),
        .load_err  (load_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [17:0] exp_of(input logic [15:0] a);
        if (a < 16'h4000) return {4'b0001, a[13:0]};
        if (a < 16'h5000) return {4'b0010, 14'(a - 16'h4000)};
        if (a < 16'h6000) return {4'b0100, 14'(a - 16'h5000)};
        if (a < 16'h6200) return {4'b1000, 14'(a - 16'h6000)};
        return '0;
    endfunction

    function automatic logic [7:0] data_of(input logic [15:0] a);
        return a[7:0] ^ {a[12:8], a[15:13]} ^ 8'h5A;
    endfunction

    // Monitor: every strobe must match the oldest outstanding expected write.
    always @(negedge clk) begin
        if (rom_we != 4'b0000) begin
            strobes++;
            for (int i = 0; i < 4; i++) if (rom_we[i]) reg_cnt[i]++;
            if (sb.size() == 0) chk("unexpected strobe", {6'd0, rom_we, rom_addr, rom_data}, 32'd0);
            else begin
                m = sb.pop_front();
                chk("strobe", {6'd0, rom_we, rom_addr, rom_data}, {6'd0, m.we, m.addr, m.data});
                if (m.bnd >= 0) begin
                    bnd_seen[m.bnd] = 1'b1;
                    bnd_we[m.bnd]   = rom_we;
                    bnd_addr[m.bnd] = rom_addr;
                end
            end
        end
    end

    task automatic wr(input logic [15:0] a, input bit drop);
        exp_t        e;
        logic [17:0] x;
        @(posedge clk); #1;
        dl_wr   = 1'b1;
        dl_addr = a;
        dl_data = data_of(a);
        if (drop) dl_active = 1'b0;
        x      = exp_of(a);
        e.we   = x[17:14];
        e.addr = x[13:0];
        e.data = dl_data;
        e.bnd  = a == 16'h3FFF ? 0 : a == 16'h4000 ? 1 : a == 16'h5FFF ? 2 : a == 16'h6000 ? 3 : -1;
        if (e.we != 4'b0000) sb.push_back(e);
    endtask

    // The junk write on the entry edge must be ignored.
    task automatic start_load();
        @(posedge clk); #1;
        dl_active = 1'b1;
        dl_wr     = 1'b1;
        dl_addr   = 16'h0123;
        dl_data   = 8'hEE;
    endtask

    task automatic do_load(input int first, input int last, input bit oor);
        start_load();
        for (int a = first; a <= last; a++) wr(16'(a), a == last && !oor);
        if (oor) wr(16'h7000, 1'b1);
        @(posedge clk); #1;
        dl_wr = 1'b0;
    endtask

    task automatic count_high(input int limit, input int soft_drop, output int n);
        n = 0;
        while (core_reset === 1'b1 && n < limit) begin
            n++;
            if (n == soft_drop) soft_reset = 1'b0;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #(950000);
        $display("FAIL watchdog: run exceeded its cycle budget");
        $fatal(1, "timeout");
    end

    initial begin
        int n, s0;
        for (int i = 0; i < 4; i++) begin
            reg_cnt[i] = 0; bnd_seen[i] = 1'b0; bnd_we[i] = '0; bnd_addr[i] = '0;
        end
        #1 reset_n = 1'b0;
        #22;
        chk("reset rom outputs", {6'd0, rom_we, rom_addr, rom_data}, 32'd0);
        chk("reset flags", {29'd0, core_reset, load_ok, load_err}, 32'b100);
        @(posedge clk); #1;
        reset_n = 1'b1;

        soft_reset = 1'b1;
        count_high(20, 3, n);
        chk("soft_reset in EMPTY ignored", n, 20);

        do_load(0, 16'h61FE, 1'b0);
        chk("short flags in CHECK", {load_ok, load_err}, 2'b00);
        @(posedge clk); #1;
        chk("short load flags", {load_ok, load_err}, 2'b01);
        soft_reset = 1'b1;
        count_high(200, 3, n);
        chk("FAULT holds core_reset", n, 200);
        chk("FAULT flags kept", {load_ok, load_err}, 2'b01);

        for (int i = 0; i < 4; i++) begin reg_cnt[i] = 0; bnd_seen[i] = 1'b0; end
        do_load(0, 16'h61FF, 1'b0);
        chk("full flags in CHECK", {load_ok, load_err}, 2'b00);
        @(posedge clk); #1;
        chk("full load flags", {load_ok, load_err}, 2'b10);
        count_high(2000, 0, n);
        chk("post-load stretch cycles", n, 64);
        chk("prog strobes", reg_cnt[0], 16384);
        chk("bg strobes", reg_cnt[1], 4096);
        chk("fg strobes", reg_cnt[2], 4096);
        chk("prom strobes", reg_cnt[3], 512);
        chk("boundary 0x3FFF", {bnd_seen[0], bnd_we[0], bnd_addr[0]}, {1'b1, 4'b0001, 14'h3FFF});
        chk("boundary 0x4000", {bnd_seen[1], bnd_we[1], bnd_addr[1]}, {1'b1, 4'b0010, 14'h0000});
        chk("boundary 0x5FFF", {bnd_seen[2], bnd_we[2], bnd_addr[2]}, {1'b1, 4'b0100, 14'h0FFF});
        chk("boundary 0x6000", {bnd_seen[3], bnd_we[3], bnd_addr[3]}, {1'b1, 4'b1000, 14'h0000});
        chk("scoreboard drained", sb.size(), 0);

        s0 = strobes;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            dl_wr = 1'b1; dl_addr = 16'(16'h0040 + i); dl_data = 8'h11;
        end
        @(posedge clk); #1;
        dl_wr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("dl_wr in RUN ignored", strobes - s0, 0);
        chk("RUN core_reset", core_reset, 0);

        soft_reset = 1'b1;
        @(posedge clk); #1;
        count_high(2000, 3, n);
        chk("soft reset stretch cycles", n, 66);
        chk("load_ok after soft reset", {load_ok, load_err}, 2'b10);

        s0 = strobes;
        do_load(0, 16'h61FF, 1'b1);
        @(posedge clk); #1;
        chk("out-of-range flags", {load_ok, load_err}, 2'b01);
        chk("out-of-range strobe count", strobes - s0, 25088);
        count_high(100, 0, n);
        chk("out-of-range FAULT", n, 100);

        start_load();
        for (int a = 0; a <= 16'h2000; a++) wr(16'(a), 1'b0);
        @(posedge clk); #2;
        chk("strobe before async reset", {rom_we, rom_addr, rom_data}, {4'b0001, 14'h2000, data_of(16'h2000)});
        reset_n = 1'b0; dl_wr = 1'b0; dl_active = 1'b0;
        #1;
        chk("async reset rom outputs", {6'd0, rom_we, rom_addr, rom_data}, 32'd0);
        chk("async reset flags", {29'd0, core_reset, load_ok, load_err}, 32'b100);
        chk("pending write at reset", sb.size(), 1);
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        s0 = strobes;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            dl_wr = 1'b1; dl_addr = 16'(16'h0010 + i); dl_data = 8'h77;
        end
        @(posedge clk); #1;
        dl_wr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("dl_wr after reset ignored", strobes - s0, 0);
        chk("EMPTY after reset", {29'd0, core_reset, load_ok, load_err}, 32'b100);
        do_load(16'h6000, 16'h6003, 1'b0);
        @(posedge clk); #1;
        chk("reload strobes", strobes - s0, 4);
        chk("reload short flags", {load_ok, load_err}, 2'b01);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
